// File: rtl/ss_scan_ctrl.sv
// Snake-game score keeper: 4-digit BCD counter with saturation at 9999
// and a time-multiplexed digit scanner for the seven-segment display.
module ss_scan_ctrl #(
    parameter int         REFRESH_DIV = 100000,
    parameter bit         BLANK_LZ    = 1'b1,
    parameter logic [3:0] DP_MASK     = 4'b0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        score_inc,
    input  logic        score_clr,
    input  logic        hold,
    output logic [3:0]  an,
    output logic [3:0]  digit_val,
    output logic        dp_sel,
    output logic        score_max,
    output logic [15:0] score_bcd
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] refCnt;
    logic [1:0]    idx;
    logic [15:0]   score;
    logic [15:0]   scoreNext;
    logic          carry;
    logic [3:0]    curDigit;
    logic          blanked;
    logic [3:0]    anNext;
    logic          dpNext;

    always_comb begin
        scoreNext = score;
        carry     = 1'b0;
        if (score_clr) begin
            scoreNext = '0;
        end else if (score_inc && !hold && score != 16'h9999) begin
            // ripple the decimal carry through all digits in one cycle
            carry = 1'b1;
            for (int k = 0; k < 4; k++) begin
                if (carry) begin
                    if (score[4*k +: 4] == 4'd9) begin
                        scoreNext[4*k +: 4] = 4'd0;
                    end else begin
                        scoreNext[4*k +: 4] = score[4*k +: 4] + 4'd1;
                        carry = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        curDigit = score[3:0];
        blanked  = 1'b0;
        unique case (idx)
            2'd0: begin
                curDigit = score[3:0];
                blanked  = 1'b0;
            end
            2'd1: begin
                curDigit = score[7:4];
                blanked  = BLANK_LZ && (score[15:4] == 12'h000);
            end
            2'd2: begin
                curDigit = score[11:8];
                blanked  = BLANK_LZ && (score[15:8] == 8'h00);
            end
            2'd3: begin
                curDigit = score[15:12];
                blanked  = BLANK_LZ && (score[15:12] == 4'h0);
            end
        endcase
        anNext = blanked ? 4'b1111 : ~(4'b0001 << idx);
        dpNext = blanked ? 1'b1 : ~DP_MASK[idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            score     <= '0;
            score_max <= 1'b0;
        end else begin
            score     <= scoreNext;
            score_max <= (scoreNext == 16'h9999);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            refCnt <= '0;
            idx    <= 2'd0;
        end else if (refCnt == TERM) begin
            refCnt <= '0;
            idx    <= idx + 2'd1;
        end else begin
            refCnt <= refCnt + CW'(1);
        end
    end

    // outputs are registered so an never shows two low bits mid-transition
    always_ff @(posedge clk) begin
        if (rst) begin
            an        <= 4'b1111;
            digit_val <= 4'd0;
            dp_sel    <= 1'b1;
        end else begin
            an        <= anNext;
            digit_val <= curDigit;
            dp_sel    <= dpNext;
        end
    end

    assign score_bcd = score;

endmodule

// File: tb/tb_ss_scan_ctrl.sv
// Randomized bench for ss_scan_ctrl against an integer-arithmetic model;
// two instances cover blanking on/off and a decimal-point mask.
module tb_ss_scan_ctrl;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst, inc, clr, hold;
    logic [3:0]  an0, dv0, an1, dv1;
    logic        dp0, dp1, max0, max1;
    logic [15:0] bcd0, bcd1;

    int vecs = 0;
    int errs = 0;

    int mScore;
    int mCnt;
    logic [8:0] e0, e1;

    always #5 clk = ~clk;

    ss_scan_ctrl #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b1), .DP_MASK(4'b0000)) u0 (
        .clk(clk), .rst(rst), .score_inc(inc), .score_clr(clr), .hold(hold),
        .an(an0), .digit_val(dv0), .dp_sel(dp0),
        .score_max(max0), .score_bcd(bcd0)
    );

    ss_scan_ctrl #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b0), .DP_MASK(4'b0010)) u1 (
        .clk(clk), .rst(rst), .score_inc(inc), .score_clr(clr), .hold(hold),
        .an(an1), .digit_val(dv1), .dp_sel(dp1),
        .score_max(max1), .score_bcd(bcd1)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] toBcd(input int s);
        return {4'(s / 1000 % 10), 4'(s / 100 % 10),
                4'(s / 10 % 10), 4'(s % 10)};
    endfunction

    // {an, digit, dp} for the digit at position idx of decimal score s
    function automatic logic [8:0] expOut(input int s, input int idx,
                                          input bit blz,
                                          input logic [3:0] mask);
        int p[4] = '{1, 10, 100, 1000};
        int d;
        bit blank;
        logic [3:0] a;
        d     = (s / p[idx]) % 10;
        blank = blz && idx > 0 && s < p[idx];
        a     = 4'hF;
        if (!blank) a[idx] = 1'b0;
        return {a, 4'(d), blank ? 1'b1 : ~mask[idx]};
    endfunction

    task automatic step(input logic r, input logic i,
                        input logic c, input logic h);
        rst = r; inc = i; clr = c; hold = h;
        @(posedge clk);
        if (r) begin
            mScore = 0;
            mCnt   = 0;
            e0     = {4'hF, 4'h0, 1'b1};
            e1     = {4'hF, 4'h0, 1'b1};
        end else begin
            e0 = expOut(mScore, (mCnt / DIV) % 4, 1'b1, 4'b0000);
            e1 = expOut(mScore, (mCnt / DIV) % 4, 1'b0, 4'b0010);
            mCnt++;
            if (c) mScore = 0;
            else if (i && !h && mScore < 9999) mScore++;
        end
        @(negedge clk);
        chk("an0", 32'(an0), 32'(e0[8:5]));
        chk("dv0", 32'(dv0), 32'(e0[4:1]));
        chk("dp0", 32'(dp0), 32'(e0[0]));
        chk("an1", 32'(an1), 32'(e1[8:5]));
        chk("dv1", 32'(dv1), 32'(e1[4:1]));
        chk("dp1", 32'(dp1), 32'(e1[0]));
        chk("bcd", 32'(bcd0), 32'(toBcd(mScore)));
        chk("max", 32'(max0), 32'(mScore == 9999));
        chk("bcd1", 32'(bcd1), 32'(toBcd(mScore)));
        chk("onehot0", 32'($countones(~an0) <= 1), 32'd1);
        chk("onehot1", 32'($countones(~an1) <= 1), 32'd1);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pulses(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; inc = 1'b0; clr = 1'b0; hold = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(24);

        pulses(123);
        chk("bcd123", 32'(bcd0), 32'h0123);
        idle(24);

        step(1'b0, 1'b0, 1'b1, 1'b0);
        pulses(999);
        idle(3);
        pulses(1);
        chk("carry", 32'(bcd0), 32'h1000);
        idle(20);

        pulses(8999);
        chk("sat", 32'(max0), 32'd1);
        pulses(5);
        chk("satHold", 32'(bcd0), 32'h9999);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("clrPri", 32'({max0, bcd0}), 32'h0);

        pulses(7);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b1, 1'b0, 1'b1);
            step(1'b0, 1'b0, 1'b0, 1'b1);
        end
        chk("hold", 32'(bcd0), 32'h0007);
        pulses(1);
        chk("release", 32'(bcd0), 32'h0008);

        step(1'b0, 1'b0, 1'b1, 1'b0);
        pulses(42);
        idle(18);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("rstAn", 32'(an1), 32'hF);
        idle(20);

        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 49) == 0,
                 $urandom_range(0, 9) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
